// File: rtl/tiny_cpu_control.sv
// rtl/tiny_cpu_control.sv - hardwired multi-cycle control unit for the TinyCPU datapath
module tiny_cpu_control #(
  parameter int                 BITS     = 16,
  parameter int                 PC_BITS  = 16,
  parameter logic [PC_BITS-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_BITS-1:0] imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [15:0]        imem_data,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic               LoadEnable,
  output logic [1:0]         ASelect,
  output logic [1:0]         BSelect,
  output logic [1:0]         DestinationSelect,
  output logic [BITS-1:0]    ConstantIn,
  output logic               MBSelect,
  output logic               MDSelect,
  output logic               MFSelect,
  output logic [3:0]         GSelect,
  output logic [1:0]         HSelect,
  input  logic               statC,
  input  logic               statV,
  input  logic               statN,
  input  logic               statZ,
  output logic               halted
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_ST   = 4'hC;
  localparam logic [3:0] OP_BZ   = 4'hD;
  localparam logic [3:0] OP_BN   = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  state_t             state_q, state_d;
  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [15:0]        ir_q, ir_d;
  logic [3:0]         flags_q, flags_d;   // {C, V, N, Z}

  // Registered control word; each is the decode of the state/IR being entered.
  logic       imem_req_q, imem_req_d;
  logic       dmem_req_q, dmem_req_d;
  logic       dmem_we_q, dmem_we_d;
  logic       load_enable_q, load_enable_d;
  logic       halted_q, halted_d;
  logic       mb_q, mb_d;
  logic       md_q, md_d;
  logic       mf_q, mf_d;
  logic [3:0] g_q, g_d;
  logic [1:0] h_q, h_d;

  logic [3:0]         op_q, op_d;
  logic [PC_BITS-1:0] branch_off;

  assign op_q       = ir_q[15:12];
  assign op_d       = ir_d[15:12];
  assign branch_off = {{(PC_BITS-6){ir_q[5]}}, ir_q[5:0]};

  // Sequencing: fetch handshake, execute side effects, memory wait, halt.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    case (state_q)
      S_FETCH: begin
        // imem_req_q is low for the first cycle out of reset, so a stray ack there is ignored
        if (imem_req_q && imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + PC_BITS'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_q >= OP_ADD && op_q <= OP_ADDI && op_q != OP_LDI)
          flags_d = {statC, statV, statN, statZ};
        // pc_q already points past the branch, so the offset is relative to the next instruction
        if ((op_q == OP_BZ && flags_q[0]) || (op_q == OP_BN && flags_q[1]))
          pc_d = pc_q + branch_off;
        if (op_q == OP_LD || op_q == OP_ST) state_d = S_MEM;
        else if (op_q == OP_HLT)            state_d = S_HALT;
        else                                state_d = S_FETCH;
      end
      S_MEM: begin
        if (dmem_ack) state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  // Control word decode for the upcoming cycle.
  always_comb begin
    imem_req_d    = (state_d == S_FETCH);
    dmem_req_d    = (state_d == S_MEM);
    dmem_we_d     = (state_d == S_MEM) && (op_d == OP_ST);
    load_enable_d = (state_d == S_EXEC) && (op_d >= OP_ADD) && (op_d <= OP_ADDI);
    halted_d      = (state_d == S_HALT);
    mb_d = 1'b0;
    md_d = 1'b0;
    mf_d = 1'b0;
    g_d  = 4'b0000;
    h_d  = 2'b00;
    case (op_d)
      OP_ADD:  g_d = 4'b0010;
      OP_SUB:  g_d = 4'b0101;
      OP_AND:  g_d = 4'b1000;
      OP_OR:   g_d = 4'b1010;
      OP_XOR:  g_d = 4'b1100;
      OP_NOT:  g_d = 4'b1110;
      OP_SHL:  begin mf_d = 1'b1; h_d = 2'b10; end
      OP_SHR:  begin mf_d = 1'b1; h_d = 2'b01; end
      OP_LDI:  begin mb_d = 1'b1; mf_d = 1'b1; h_d = 2'b00; end
      OP_ADDI: begin mb_d = 1'b1; g_d = 4'b0010; end
      OP_LD:   md_d = 1'b1;
      default: ;
    endcase
  end

  // State, architectural registers and control word flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      flags_q       <= '0;
      imem_req_q    <= 1'b0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      load_enable_q <= 1'b0;
      halted_q      <= 1'b0;
      mb_q          <= 1'b0;
      md_q          <= 1'b0;
      mf_q          <= 1'b0;
      g_q           <= '0;
      h_q           <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      flags_q       <= flags_d;
      imem_req_q    <= imem_req_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      load_enable_q <= load_enable_d;
      halted_q      <= halted_d;
      mb_q          <= mb_d;
      md_q          <= md_d;
      mf_q          <= mf_d;
      g_q           <= g_d;
      h_q           <= h_d;
    end
  end

  assign imem_addr         = pc_q;
  assign imem_req          = imem_req_q;
  assign dmem_req          = dmem_req_q;
  assign dmem_we           = dmem_we_q;
  // Load data is only valid in the ack cycle, so the LD write strobe follows dmem_ack directly.
  assign LoadEnable        = load_enable_q | ((state_q == S_MEM) && (op_q == OP_LD) && dmem_ack);
  assign ASelect           = ir_q[9:8];
  assign BSelect           = ir_q[7:6];
  assign DestinationSelect = ir_q[11:10];
  assign ConstantIn        = {{(BITS-6){1'b0}}, ir_q[5:0]};
  assign MBSelect          = mb_q;
  assign MDSelect          = md_q;
  assign MFSelect          = mf_q;
  assign GSelect           = g_q;
  assign HSelect           = h_q;
  assign halted            = halted_q;

endmodule

// File: tb/tb_tiny_cpu_control.sv
// tb/tb_tiny_cpu_control.sv - directed self-checking bench for tiny_cpu_control
module tb_tiny_cpu_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic        LoadEnable;
  logic [1:0]  ASelect, BSelect, DestinationSelect;
  logic [15:0] ConstantIn;
  logic        MBSelect, MDSelect, MFSelect;
  logic [3:0]  GSelect;
  logic [1:0]  HSelect;
  logic        statC = 1'b0, statV = 1'b0, statN = 1'b0, statZ = 1'b0;
  logic        halted;

  int tests_run = 0;
  int failed = 0;

  logic [15:0] imem [16];
  assign imem_data = imem[imem_addr[3:0]];

  always #5 clk = ~clk;

  tiny_cpu_control #(.BITS(16), .PC_BITS(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .LoadEnable(LoadEnable), .ASelect(ASelect), .BSelect(BSelect),
    .DestinationSelect(DestinationSelect), .ConstantIn(ConstantIn),
    .MBSelect(MBSelect), .MDSelect(MDSelect), .MFSelect(MFSelect),
    .GSelect(GSelect), .HSelect(HSelect),
    .statC(statC), .statV(statV), .statN(statN), .statZ(statZ),
    .halted(halted)
  );

  task automatic to_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 16; i++) imem[i] = 16'h0000;
  endtask

  // Leaves the bench in the first cycle with rst_n high again.
  task automatic do_reset();
    to_cycle();
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; statZ = 1'b0; statN = 1'b0;
    to_cycle();
    to_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    to_cycle();
    to_cycle();
    mid();
    tests_run++; if ({imem_req, dmem_req, LoadEnable, halted} !== 4'b0000) begin failed++; $display("FAIL reset_strobes: got %b expected 0000", {imem_req, dmem_req, LoadEnable, halted}); end
    tests_run++; if (imem_addr !== 16'h0000) begin failed++; $display("FAIL reset_pc: got %h expected 0000", imem_addr); end
    to_cycle();
    rst_n = 1'b1;
    mid();
    tests_run++; if (imem_req !== 1'b0) begin failed++; $display("FAIL reset_release_req: got %b expected 0", imem_req); end
    to_cycle();
    mid();
    tests_run++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin failed++; $display("FAIL first_fetch: got req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr); end
  endtask

  task automatic test_alu_seq();
    logic [6:0] le_exp;
    logic [6:0] req_exp;
    le_exp  = 7'b0101010;
    req_exp = 7'b1010101;
    clear_imem();
    imem[0] = 16'h9405;  // LDI R1,5
    imem[1] = 16'h9803;  // LDI R2,3
    imem[2] = 16'h1D80;  // ADD R3,R1,R2
    imem[3] = 16'h2140;  // SUB R0,R1,R1
    imem[4] = 16'hD03D;  // BZ -3
    imem[5] = 16'hB900;  // LD R2,[R1]
    imem[6] = 16'hC0C0;  // ST [R0],R3
    imem[7] = 16'h0000;  // NOP
    imem[8] = 16'hF000;  // HLT
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      to_cycle();
      imem_ack = 1'b1;
      statZ = 1'b0;
      mid();
      tests_run++; if (LoadEnable !== le_exp[c-1]) begin failed++; $display("FAIL alu_le_c%0d: got %b expected %b", c, LoadEnable, le_exp[c-1]); end
      tests_run++; if (imem_req !== req_exp[c-1]) begin failed++; $display("FAIL alu_req_c%0d: got %b expected %b", c, imem_req, req_exp[c-1]); end
      if (c == 2) begin
        tests_run++; if ({MBSelect, MFSelect, HSelect, DestinationSelect, ConstantIn} !== {1'b1, 1'b1, 2'b00, 2'd1, 16'd5}) begin failed++; $display("FAIL ldi_word: got mb=%b mf=%b h=%b d=%0d k=%h expected mb=1 mf=1 h=00 d=1 k=0005", MBSelect, MFSelect, HSelect, DestinationSelect, ConstantIn); end
      end
      if (c == 6) begin
        tests_run++; if ({GSelect, MBSelect, MFSelect, MDSelect, ASelect, BSelect, DestinationSelect} !== {4'b0010, 3'b000, 2'd1, 2'd2, 2'd3}) begin failed++; $display("FAIL add_word: got g=%b mb=%b mf=%b md=%b a=%0d b=%0d d=%0d expected g=0010 mb=0 mf=0 md=0 a=1 b=2 d=3", GSelect, MBSelect, MFSelect, MDSelect, ASelect, BSelect, DestinationSelect); end
      end
      if (c == 7) begin
        tests_run++; if (imem_addr !== 16'h0003) begin failed++; $display("FAIL alu_pc: got %h expected 0003", imem_addr); end
      end
    end
  endtask

  task automatic test_branch();
    for (int c = 8; c <= 17; c++) begin
      to_cycle();
      statZ = (c == 8);
      mid();
      if (c == 8) begin
        tests_run++; if ({GSelect, LoadEnable} !== {4'b0101, 1'b1}) begin failed++; $display("FAIL sub_word: got g=%b le=%b expected g=0101 le=1", GSelect, LoadEnable); end
      end
      if (c == 10) begin
        tests_run++; if (LoadEnable !== 1'b0) begin failed++; $display("FAIL bz_no_write: got %b expected 0", LoadEnable); end
      end
      if (c == 11) begin
        tests_run++; if (imem_addr !== 16'h0002) begin failed++; $display("FAIL bz_taken: got %h expected 0002", imem_addr); end
      end
      if (c == 17) begin
        tests_run++; if (imem_addr !== 16'h0005) begin failed++; $display("FAIL bz_not_taken: got %h expected 0005", imem_addr); end
      end
    end
  endtask

  task automatic test_load();
    for (int c = 18; c <= 23; c++) begin
      to_cycle();
      dmem_ack = (c == 22);
      mid();
      tests_run++; if (dmem_req !== (c >= 19 && c <= 22)) begin failed++; $display("FAIL ld_req_c%0d: got %b expected %b", c, dmem_req, (c >= 19 && c <= 22)); end
      tests_run++; if (LoadEnable !== (c == 22)) begin failed++; $display("FAIL ld_le_c%0d: got %b expected %b", c, LoadEnable, (c == 22)); end
      if (c >= 19 && c <= 22) begin
        tests_run++; if ({dmem_we, MDSelect, MBSelect} !== 3'b010) begin failed++; $display("FAIL ld_word_c%0d: got we=%b md=%b mb=%b expected we=0 md=1 mb=0", c, dmem_we, MDSelect, MBSelect); end
      end
      if (c == 23) begin
        tests_run++; if ({imem_req, imem_addr} !== {1'b1, 16'h0006}) begin failed++; $display("FAIL ld_next_fetch: got req=%b addr=%h expected req=1 addr=0006", imem_req, imem_addr); end
      end
    end
  endtask

  task automatic test_store();
    for (int c = 24; c <= 26; c++) begin
      to_cycle();
      dmem_ack = (c == 24 || c == 25);
      mid();
      tests_run++; if (LoadEnable !== 1'b0) begin failed++; $display("FAIL st_le_c%0d: got %b expected 0", c, LoadEnable); end
      tests_run++; if (dmem_req !== (c == 25)) begin failed++; $display("FAIL st_req_c%0d: got %b expected %b", c, dmem_req, (c == 25)); end
      if (c == 25) begin
        tests_run++; if (dmem_we !== 1'b1) begin failed++; $display("FAIL st_we: got %b expected 1", dmem_we); end
      end
      if (c == 26) begin
        tests_run++; if (imem_addr !== 16'h0007) begin failed++; $display("FAIL st_next_fetch: got %h expected 0007", imem_addr); end
      end
    end
  endtask

  task automatic test_spurious_ack();
    to_cycle();
    dmem_ack = 1'b0;
    imem_ack = 1'b1;
    mid();
    tests_run++; if ({imem_req, LoadEnable} !== 2'b00) begin failed++; $display("FAIL nop_exec: got req=%b le=%b expected 00", imem_req, LoadEnable); end
    to_cycle();
    mid();
    tests_run++; if ({imem_req, imem_addr} !== {1'b1, 16'h0008}) begin failed++; $display("FAIL spurious_ack: got req=%b addr=%h expected req=1 addr=0008", imem_req, imem_addr); end
  endtask

  task automatic test_halt();
    to_cycle();
    mid();
    tests_run++; if (halted !== 1'b0) begin failed++; $display("FAIL hlt_exec: got %b expected 0", halted); end
    for (int c = 0; c < 20; c++) begin
      to_cycle();
      mid();
      tests_run++; if ({halted, imem_req, dmem_req, LoadEnable} !== 4'b1000) begin failed++; $display("FAIL halt_c%0d: got %b expected 1000", c, {halted, imem_req, dmem_req, LoadEnable}); end
    end
    to_cycle();
    rst_n = 1'b0;
    to_cycle();
    mid();
    tests_run++; if ({halted, imem_req, imem_addr} !== {2'b00, 16'h0000}) begin failed++; $display("FAIL halt_reset: got halted=%b req=%b addr=%h expected 0 0 0000", halted, imem_req, imem_addr); end
    to_cycle();
    rst_n = 1'b1;
    to_cycle();
    mid();
    tests_run++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin failed++; $display("FAIL halt_restart: got req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr); end
  endtask

  task automatic test_pc_wrap();
    clear_imem();
    imem[0]  = 16'h2140;  // SUB R0,R1,R1
    imem[1]  = 16'hD03D;  // BZ -3 -> 0xFFFF
    imem[15] = 16'h0000;  // NOP at 0xFFFF
    do_reset();
    for (int c = 0; c < 3; c++) begin
      to_cycle();
      imem_ack = 1'b0;
      mid();
      tests_run++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin failed++; $display("FAIL fetch_stall_%0d: got req=%b addr=%h expected req=1 addr=0000", c, imem_req, imem_addr); end
    end
    for (int c = 1; c <= 7; c++) begin
      to_cycle();
      imem_ack = 1'b1;
      statZ = (c == 2);
      mid();
      if (c == 5) begin
        tests_run++; if (imem_addr !== 16'hFFFF) begin failed++; $display("FAIL branch_to_ffff: got %h expected ffff", imem_addr); end
      end
      if (c == 7) begin
        tests_run++; if (imem_addr !== 16'h0000) begin failed++; $display("FAIL pc_wrap: got %h expected 0000", imem_addr); end
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    clear_imem();
    imem[0] = 16'hB900;  // LD R2,[R1]
    do_reset();
    to_cycle();
    imem_ack = 1'b1;
    dmem_ack = 1'b0;
    mid();
    to_cycle();
    imem_ack = 1'b0;
    mid();
    to_cycle();
    mid();
    tests_run++; if (dmem_req !== 1'b1) begin failed++; $display("FAIL mem_wait_req: got %b expected 1", dmem_req); end
    to_cycle();
    rst_n = 1'b0;
    mid();
    to_cycle();
    mid();
    tests_run++; if ({dmem_req, imem_req, LoadEnable} !== 3'b000) begin failed++; $display("FAIL mem_reset_strobes: got %b expected 000", {dmem_req, imem_req, LoadEnable}); end
    to_cycle();
    rst_n = 1'b1;
    mid();
    to_cycle();
    mid();
    tests_run++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin failed++; $display("FAIL mem_reset_restart: got req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr); end
  endtask

  initial begin
    clear_imem();
    test_reset();
    test_alu_seq();
    test_branch();
    test_load();
    test_store();
    test_spurious_ack();
    test_halt();
    test_pc_wrap();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/tiny_cpu_control.md
Name: tiny_cpu_control

Overview:
- Hardwired multi-cycle control unit for the 16-bit TinyCPU datapath (4-entry register file, function unit, MB/MD muxes).
- Fetches 16-bit instructions over a req/ack instruction port, decodes them, and drives the datapath control word.
- Latches datapath status flags, sequences load/store handshakes on the data memory port, and owns the program counter.

Parameters:
- BITS, 16, datapath word width; ConstantIn width.
- PC_BITS, 16, program counter / imem_addr width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- imem_addr  output  PC_BITS  instruction address (= PC)
- imem_req  output  1  instruction fetch request
- imem_ack  input  1  instruction valid this cycle
- imem_data  input  16  instruction word
- dmem_req  output  1  data access request (address and data come from the datapath AddressOut/DataOut)
- dmem_we  output  1  1 = store, 0 = load; valid while dmem_req
- dmem_ack  input  1  access complete; load data valid on DataIn
- LoadEnable  output  1  register file write strobe
- ASelect, BSelect, DestinationSelect  output  2 each  register addresses
- ConstantIn  output  BITS  zero-extended imm6
- MBSelect, MDSelect, MFSelect  output  1 each  mux selects
- GSelect  output  4  ALU function
- HSelect  output  2  shifter function
- statC, statV, statN, statZ  input  1 each  datapath status flags
- halted  output  1  high in HALT

Behaviour:
- Instruction format: [15:12] op, [11:10] D, [9:8] A, [7:6] B, [5:0] imm6. ASelect/BSelect/DestinationSelect = IR fields at all times. ConstantIn = {0, imm6}.
- Datapath encodings used:
  - G: 0010 A+B, 0101 A+~B+1, 1000 AND, 1010 OR, 1100 XOR, 1110 ~A.
  - H: 00 pass B, 01 B>>1, 10 B<<1.
  - MF=1 selects shifter output.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT (D <= ~A)
  - 7 SHL (D <= B<<1), 8 SHR (D <= B>>1)
  - 9 LDI (MB=1, MF=1, H=00; D <= imm)
  - A ADDI (MB=1, G=0010)
  - B LD (D <= mem[A], MD=1)
  - C ST (mem[A] <= B)
  - D BZ, E BN: PC <= PC + sext(imm6); PC has already been incremented; arithmetic modulo 2^PC_BITS.
  - F HLT
- States: FETCH, EXEC, MEM, HALT.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - On imem_ack: IR <= imem_data, PC <= PC+1 (wraps at all-ones to 0), go to EXEC.
  - Without ack, hold indefinitely with all outputs stable.
- EXEC, exactly 1 cycle:
  - Ops 1–A: LoadEnable=1 for this cycle only. Flags register {C,V,N,Z} <= stat inputs.
  - Op 9: flags are not updated.
  - NOP, BZ, BN: no write, flags unchanged. BZ tests latched Z; BN tests latched N.
  - Ops 0–A, D, E: next state FETCH. Ops B, C: next state MEM. Op F: next state HALT.
- MEM:
  - dmem_req=1, dmem_we = (op==C). Control word is held (MB=0, MD=(op==B)).
  - Waits for dmem_ack. In the ack cycle, LD asserts LoadEnable=1 with MD=1.
  - Next state FETCH. Flags are not updated.
- HALT: halted=1, no requests, LoadEnable=0. Exit only via reset.
- LoadEnable, imem_req and dmem_req are never asserted outside the states above; at most one of imem_req and dmem_req is high at a time.
- An ack arriving while the matching req is low is ignored.
- Reset (rst_n=0 at a clock edge) in any state, including mid-wait:
  - state <= FETCH, PC <= RESET_PC, IR <= 0, flags <= 0.
  - During reset, all strobes (imem_req, dmem_req, LoadEnable) are forced 0 and halted=0.
  - The first imem_req is asserted in the cycle after rst_n rises.
- Latency with zero-wait memory:
  - ALU, branch, NOP: 2 cycles.
  - LD/ST: 3 cycles.
  - Each wait cycle adds 1.

Test Plan:
- Reset then run with ack tied high: imem_addr=0 in the first cycle after reset; sequence LDI R1,5 / LDI R2,3 / ADD R3,R1,R2 -> LoadEnable pulses in cycles 2, 4, 6 with G=0010 on the ADD; PC=3.
- SUB R0,R1,R1 with statZ=1 in EXEC, then BZ imm=-3 at address 4 -> next imem_addr = 5-3 = 2. Repeat with statZ=0 -> next imem_addr = 5.
- LD R2,[R1] with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles, dmem_we=0; LoadEnable=1 with MD=1 only in the ack cycle.
- ST [R0],R3 -> dmem_we=1 while dmem_req is high; LoadEnable stays 0 throughout.
- HLT -> halted=1 and no further imem_req for 20 cycles. Then pulse rst_n low -> imem_addr=RESET_PC and halted=0.
- Edge cases:
  - PC=0xFFFF fetch -> PC wraps to 0.
  - rst_n low mid-MEM wait -> dmem_req drops at that edge; fetch restarts at RESET_PC.
  - Spurious imem_ack in EXEC -> ignored.
